// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Provides a fallback `Ram_base when the platform header has not defined it.
`ifndef Ram_base
`define Ram_base 64'h0000_0000_8000_0000
`endif

package mem_bus_arbiter_pkg;

    localparam int BUS_AW = 64;
    localparam int BUS_DW = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        RD_WAIT = 2'd2
    } m1_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_M1   = 1'b1;

endpackage

// File: rtl/mem_bus_m1_buffer.sv
// One-entry request buffer and sequencing FSM for the secondary bus master.
// The buffered request is issued only when the top asserts issue.
module mem_bus_m1_buffer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m1_valid,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_write_data,
    input  logic          issue,
    output logic          m1_ready,
    output logic          buf_full,
    output logic          buf_write,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data,
    output logic          rd_wait,
    output logic          wdone
);

    m1_state_e     state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wdone_q, wdone_d;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wdone_d = 1'b0;
        case (state_q)
            EMPTY: begin
                if (m1_valid) begin
                    write_d = m1_write;
                    addr_d  = m1_address;
                    data_d  = m1_write_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (issue) begin
                    if (write_q) begin
                        state_d = EMPTY;
                        wdone_d = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wdone_q <= wdone_d;
        end
    end

    // Ready depends on registered state only, never on m1_valid.
    assign m1_ready  = (state_q == EMPTY);
    assign buf_full  = (state_q == FULL);
    assign rd_wait   = (state_q == RD_WAIT);
    assign buf_write = write_q;
    assign buf_addr  = addr_q;
    assign buf_data  = data_q;
    assign wdone     = wdone_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the RAM/MMIO bus between the core (absolute priority) and a buffered secondary master.
// Optional performance counters are enabled with `define MEM_BUS_ARB_PERF_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int            AW        = BUS_AW,
    parameter int            DW        = BUS_DW,
    parameter logic [AW-1:0] IDLE_ADDR = `Ram_base
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_write_data,
    input  logic          m0_write_enable,
    input  logic          m0_read_enable,
    output logic [DW-1:0] m0_read_data,
    input  logic          m1_valid,
    output logic          m1_ready,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_write_data,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_read_data,
    output logic          m1_wdone,
    output logic [AW-1:0] s_address,
    output logic [AW-1:0] s_address_cache,
    output logic [DW-1:0] s_write_data,
    output logic          s_write_enable,
    output logic          s_read_enable,
`ifdef MEM_BUS_ARB_PERF_EN
    output logic [31:0]   perf_m0_cnt,
    output logic [31:0]   perf_m1_cnt,
    output logic [31:0]   perf_m1_block_cnt,
`endif
    input  logic [DW-1:0] s_read_data
);

    logic          core_req;
    logic          issue;
    logic          buf_full;
    logic          buf_write;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic          rd_wait;

    logic          rd_owner_q, rd_owner_d;
    logic [DW-1:0] m1_read_data_q, m1_read_data_d;
    logic          m1_rvalid_q, m1_rvalid_d;

    assign core_req = m0_read_enable | m0_write_enable;
    assign issue    = buf_full & ~core_req;

    mem_bus_m1_buffer #(
        .AW (AW),
        .DW (DW)
    ) u_m1_buffer (
        .clk           (clk),
        .reset         (reset),
        .m1_valid      (m1_valid),
        .m1_write      (m1_write),
        .m1_address    (m1_address),
        .m1_write_data (m1_write_data),
        .issue         (issue),
        .m1_ready      (m1_ready),
        .buf_full      (buf_full),
        .buf_write     (buf_write),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .rd_wait       (rd_wait),
        .wdone         (m1_wdone)
    );

    always_comb begin
        s_address      = IDLE_ADDR;
        s_write_data   = '0;
        s_write_enable = 1'b0;
        s_read_enable  = 1'b0;
        if (core_req) begin
            s_address      = m0_address;
            s_write_data   = m0_write_data;
            s_write_enable = m0_write_enable;
            s_read_enable  = m0_read_enable;
        end else if (buf_full) begin
            s_address      = buf_addr;
            s_write_data   = buf_data;
            s_write_enable = buf_write;
            s_read_enable  = ~buf_write;
        end
    end

    assign s_address_cache = s_address >> 2;
    assign m0_read_data    = s_read_data;

    // The owner tag marks who launched the read whose data is on s_read_data this cycle.
    always_comb begin
        rd_owner_d     = rd_owner_q;
        m1_read_data_d = m1_read_data_q;
        m1_rvalid_d    = 1'b0;
        if (m0_read_enable) begin
            rd_owner_d = OWN_CORE;
        end else if (issue && !buf_write) begin
            rd_owner_d = OWN_M1;
        end
        if (rd_wait && rd_owner_q == OWN_M1) begin
            m1_read_data_d = s_read_data;
            m1_rvalid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner_q     <= OWN_CORE;
            m1_read_data_q <= '0;
            m1_rvalid_q    <= 1'b0;
        end else begin
            rd_owner_q     <= rd_owner_d;
            m1_read_data_q <= m1_read_data_d;
            m1_rvalid_q    <= m1_rvalid_d;
        end
    end

    assign m1_read_data = m1_read_data_q;
    assign m1_rvalid    = m1_rvalid_q;

`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_m0_q, perf_m0_d;
    logic [31:0] perf_m1_q, perf_m1_d;
    logic [31:0] perf_blk_q, perf_blk_d;

    always_comb begin
        perf_m0_d  = perf_m0_q  + {31'd0, core_req};
        perf_m1_d  = perf_m1_q  + {31'd0, issue};
        perf_blk_d = perf_blk_q + {31'd0, buf_full & core_req};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_m0_q  <= '0;
            perf_m1_q  <= '0;
            perf_blk_q <= '0;
        end else begin
            perf_m0_q  <= perf_m0_d;
            perf_m1_q  <= perf_m1_d;
            perf_blk_q <= perf_blk_d;
        end
    end

    assign perf_m0_cnt       = perf_m0_q;
    assign perf_m1_cnt       = perf_m1_q;
    assign perf_m1_block_cnt = perf_blk_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table for the slave mux plus
// hand-written multi-cycle sequences with a scoreboard for M1 read returns.
module tb_mem_bus_arbiter;

    localparam logic [63:0] IDLE = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic [63:0] m0_address, m0_write_data, m0_read_data;
    logic        m0_write_enable, m0_read_enable;
    logic        m1_valid, m1_ready, m1_write;
    logic [63:0] m1_address, m1_write_data, m1_read_data;
    logic        m1_rvalid, m1_wdone;
    logic [63:0] s_address, s_address_cache, s_write_data, s_read_data;
    logic        s_write_enable, s_read_enable;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0] perf_m0_cnt, perf_m1_cnt, perf_m1_block_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    mem_bus_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .m0_address      (m0_address),
        .m0_write_data   (m0_write_data),
        .m0_write_enable (m0_write_enable),
        .m0_read_enable  (m0_read_enable),
        .m0_read_data    (m0_read_data),
        .m1_valid        (m1_valid),
        .m1_ready        (m1_ready),
        .m1_write        (m1_write),
        .m1_address      (m1_address),
        .m1_write_data   (m1_write_data),
        .m1_rvalid       (m1_rvalid),
        .m1_read_data    (m1_read_data),
        .m1_wdone        (m1_wdone),
        .s_address       (s_address),
        .s_address_cache (s_address_cache),
        .s_write_data    (s_write_data),
        .s_write_enable  (s_write_enable),
        .s_read_enable   (s_read_enable),
`ifdef MEM_BUS_ARB_PERF_EN
        .perf_m0_cnt       (perf_m0_cnt),
        .perf_m1_cnt       (perf_m1_cnt),
        .perf_m1_block_cnt (perf_m1_block_cnt),
`endif
        .s_read_data     (s_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] slave_val(input logic [63:0] a);
        if (a == 64'h8000_0010) return 64'h1122_3344_5566_7788;
        return {~a[31:0], a[31:0]};
    endfunction

    // 1-cycle-latency slave model
    always @(posedge clk) s_read_data <= s_read_enable ? slave_val(s_address) : 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every M1 read return is compared against the queued expectation.
    always @(negedge clk) begin
        if (reset && m1_rvalid) begin
            if (exp_q.size() == 0) check("rvalid_unexpected", {63'd0, m1_rvalid}, 64'd0);
            else check("m1_rdata_sb", m1_read_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_address = 64'h0; m0_write_data = 64'h0;
        m0_write_enable = 1'b0; m0_read_enable = 1'b0;
        m1_valid = 1'b0; m1_write = 1'b0;
        m1_address = 64'h0; m1_write_data = 64'h0;
    endtask

    task automatic m1_req(input logic wr, input logic [63:0] a, input logic [63:0] d);
        m1_valid = 1'b1; m1_write = wr; m1_address = a; m1_write_data = d;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wd;
        logic        we;
        logic        re;
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
        logic        exp_we;
        logic        exp_re;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] blk0, m00;

    initial begin
        vecs[0] = '{64'h0,          64'h0,  1'b0, 1'b0, IDLE,          64'h0,  1'b0, 1'b0};
        vecs[1] = '{64'h8000_0200,  64'h55, 1'b1, 1'b0, 64'h8000_0200, 64'h55, 1'b1, 1'b0};
        vecs[2] = '{64'h1000_0000,  64'h99, 1'b0, 1'b1, 64'h1000_0000, 64'h99, 1'b0, 1'b1};
        vecs[3] = '{64'h8000_0300,  64'h77, 1'b1, 1'b1, 64'h8000_0300, 64'h77, 1'b1, 1'b1};
        vecs[4] = '{64'h8000_0008,  64'h0,  1'b0, 1'b1, 64'h8000_0008, 64'h0,  1'b0, 1'b1};

        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_addr", s_address, IDLE);
        check("rst_s_en", {62'd0, s_write_enable, s_read_enable}, 64'd0);
        check("rst_ready", {63'd0, m1_ready}, 64'd1);
        check("rst_pulses", {62'd0, m1_rvalid, m1_wdone}, 64'd0);
        check("rst_m1_rdata", m1_read_data, 64'd0);
        tick();
        reset = 1'b1;

        // Core read in an idle system
        tick();
        m0_address = 64'h8000_0010; m0_read_enable = 1'b1;
        @(negedge clk);
        check("core_rd_en", {63'd0, s_read_enable}, 64'd1);
        check("core_rd_addr", s_address, 64'h8000_0010);
        check("core_rd_cache", s_address_cache, 64'h2000_0004);
        tick();
        idle_inputs();
        @(negedge clk);
        check("core_rd_data", m0_read_data, 64'h1122_3344_5566_7788);
        check("core_rd_no_m1", {63'd0, m1_rvalid}, 64'd0);

        // Slave mux vector table, M1 buffer empty
        foreach (vecs[i]) begin
            tick();
            m0_address = vecs[i].addr; m0_write_data = vecs[i].wd;
            m0_write_enable = vecs[i].we; m0_read_enable = vecs[i].re;
            @(negedge clk);
            check($sformatf("vec%0d_addr", i), s_address, vecs[i].exp_addr);
            check($sformatf("vec%0d_cache", i), s_address_cache, vecs[i].exp_addr >> 2);
            check($sformatf("vec%0d_wd", i), s_write_data, vecs[i].exp_wd);
            check($sformatf("vec%0d_en", i), {62'd0, s_write_enable, s_read_enable},
                  {62'd0, vecs[i].exp_we, vecs[i].exp_re});
        end
        tick();
        idle_inputs();

        // M1 write with core idle
        tick();
        m1_req(1'b1, 64'h8000_0100, 64'hDEAD);
        @(negedge clk);
        check("m1w_c0_ready", {63'd0, m1_ready}, 64'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("m1w_c1_we", {63'd0, s_write_enable}, 64'd1);
        check("m1w_c1_addr", s_address, 64'h8000_0100);
        check("m1w_c1_wd", s_write_data, 64'hDEAD);
        check("m1w_c1_ready", {63'd0, m1_ready}, 64'd0);
        tick();
        @(negedge clk);
        check("m1w_c2_wdone", {63'd0, m1_wdone}, 64'd1);
        check("m1w_c2_ready", {63'd0, m1_ready}, 64'd1);
        check("m1w_c2_we", {63'd0, s_write_enable}, 64'd0);
        tick();
        @(negedge clk);
        check("m1w_c3_wdone", {63'd0, m1_wdone}, 64'd0);

        // M1 read blocked by three consecutive core writes
        tick();
`ifdef MEM_BUS_ARB_PERF_EN
        blk0 = perf_m1_block_cnt; m00 = perf_m0_cnt;
`else
        blk0 = 32'd0; m00 = 32'd0;
`endif
        m1_req(1'b0, 64'h8000_0400, 64'h0);
        exp_q.push_back(slave_val(64'h8000_0400));
        for (int c = 1; c <= 3; c++) begin
            tick();
            idle_inputs();
            m0_address = 64'h8000_0500 + 64'(c); m0_write_data = 64'(c); m0_write_enable = 1'b1;
            @(negedge clk);
            check($sformatf("blk%0d_core_addr", c), s_address, 64'h8000_0500 + 64'(c));
            check($sformatf("blk%0d_no_m1_rd", c), {63'd0, s_read_enable}, 64'd0);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        check("blk_issue_re", {63'd0, s_read_enable}, 64'd1);
        check("blk_issue_addr", s_address, 64'h8000_0400);
        tick();
        @(negedge clk);
        check("blk_rdwait_rvalid", {63'd0, m1_rvalid}, 64'd0);
        tick();
        @(negedge clk);
        check("blk_rvalid", {63'd0, m1_rvalid}, 64'd1);
`ifdef MEM_BUS_ARB_PERF_EN
        check("perf_block", 64'(perf_m1_block_cnt - blk0), 64'd3);
        check("perf_m0", 64'(perf_m0_cnt - m00), 64'd3);
`endif

        // M1 read issued at N, core read at N+1
        tick();
        m1_req(1'b0, 64'h8000_0600, 64'h0);
        exp_q.push_back(slave_val(64'h8000_0600));
        tick();
        idle_inputs();
        @(negedge clk);
        check("ovl_n_addr", s_address, 64'h8000_0600);
        tick();
        m0_address = 64'h8000_0700; m0_read_enable = 1'b1;
        @(negedge clk);
        check("ovl_n1_addr", s_address, 64'h8000_0700);
        tick();
        idle_inputs();
        @(negedge clk);
        check("ovl_n2_rvalid", {63'd0, m1_rvalid}, 64'd1);
        check("ovl_n2_m1_data", m1_read_data, slave_val(64'h8000_0600));
        check("ovl_n2_m0_data", m0_read_data, slave_val(64'h8000_0700));
        tick();
        @(negedge clk);
        check("ovl_n3_hold", m1_read_data, slave_val(64'h8000_0600));
        check("ovl_n3_rvalid", {63'd0, m1_rvalid}, 64'd0);

        // Reset asserted during RD_WAIT discards the read
        tick();
        m1_req(1'b0, 64'h8000_0800, 64'h0);
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstrd_ready", {63'd0, m1_ready}, 64'd1);
        check("rstrd_addr", s_address, IDLE);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstrd_no_rvalid%0d", c), {63'd0, m1_rvalid}, 64'd0);
            check($sformatf("rstrd_ready%0d", c), {63'd0, m1_ready}, 64'd1);
            tick();
        end
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case a sequence never returns.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
